tile_sequencer: RTL and testbench

Instruction sequencer placed in front of one `computationTile`. It accepts `{opcode, operand0, operand1}` instructions from a host over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the tile, holding each opcode for that opcode's fixed latency. It captures `data_out` and returns the result over a second valid/ready interface, so the host never has to time tile operations by hand.

---
 rtl/tile_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_tile_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer.sv
// Issues buffered host instructions one at a time to a computation tile and returns each tile result.
// Issue 1 cycle after push; result LAT cycles after issue; in_ready low when FIFO full, result held until res_ready.

module seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    clear_b,
    input  logic                    wr_vld,
    output logic                    wr_rdy,
    input  logic [WIDTH-1:0]        wr_dat,
    output logic                    rd_vld,
    input  logic                    rd_rdy,
    output logic [WIDTH-1:0]        rd_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = count < (AW+1)'(DEPTH);
    assign rd_vld = count != '0;
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module tile_sequencer #(
    parameter int DEPTH      = 4,
    parameter int LAT_SINGLE = 1,
    parameter int LAT_MULTI  = 6
) (
    input  logic                    clock,
    input  logic                    clear_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_opcode,
    input  logic [15:0]             in_a,
    input  logic [15:0]             in_b,
    output logic [3:0]              tile_opcode,
    output logic [15:0]             tile_in0,
    output logic [15:0]             tile_in1,
    input  logic [15:0]             tile_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [15:0]             res_data,
    output logic [3:0]              res_opcode,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int LAT_MAX = (LAT_MULTI > LAT_SINGLE) ? LAT_MULTI : LAT_SINGLE;
    localparam int CW      = $clog2(LAT_MAX + 1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MULTI = 4'h3;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
    } instr_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    instr_t   in_dat;
    instr_t   head;
    logic     head_vld;
    logic     head_pop;

    state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  tile_opcode_d;
    logic [15:0] tile_in0_d, tile_in1_d;
    logic        res_valid_d;
    logic [15:0] res_data_d;
    logic [3:0]  res_opcode_d;

    assign in_dat = {in_opcode, in_a, in_b};

    seq_fifo #(
        .WIDTH ($bits(instr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear_b (clear_b),
        .wr_vld  (in_valid),
        .wr_rdy  (in_ready),
        .wr_dat  (in_dat),
        .rd_vld  (head_vld),
        .rd_rdy  (head_pop),
        .rd_dat  (head),
        .count   (fifo_count)
    );

    assign busy = (state_q != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tile_opcode_d = tile_opcode;
        tile_in0_d    = tile_in0;
        tile_in1_d    = tile_in1;
        res_valid_d   = res_valid;
        res_data_d    = res_data;
        res_opcode_d  = res_opcode;
        head_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                // NOPs are popped and dropped here without ever reaching the tile.
                if (head_vld) begin
                    head_pop = 1'b1;
                    if (head.opcode != OP_NOP) begin
                        tile_opcode_d = head.opcode;
                        tile_in0_d    = head.a;
                        tile_in1_d    = head.b;
                        cnt_d         = (head.opcode == OP_MULTI) ? CW'(LAT_MULTI) : CW'(LAT_SINGLE);
                        state_d       = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_data_d    = tile_out;
                    res_opcode_d  = tile_opcode;
                    res_valid_d   = 1'b1;
                    tile_opcode_d = OP_NOP;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tile_opcode <= '0;
            tile_in0    <= '0;
            tile_in1    <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_opcode  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_opcode <= tile_opcode_d;
            tile_in0    <= tile_in0_d;
            tile_in1    <= tile_in1_d;
            res_valid   <= res_valid_d;
            res_data    <= res_data_d;
            res_opcode  <= res_opcode_d;
        end
    end
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with a behavioural tile: sum of operands, opcode 3 valid only on its 6th cycle.

module tb_tile_sequencer;
    logic        clock = 1'b0;
    logic        clear_b;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  tile_opcode;
    logic [15:0] tile_in0;
    logic [15:0] tile_in1;
    logic [15:0] tile_out = 16'h0000;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_opcode;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clock = ~clock;

    tile_sequencer #(
        .DEPTH      (4),
        .LAT_SINGLE (1),
        .LAT_MULTI  (6)
    ) dut (
        .clock       (clock),
        .clear_b     (clear_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .tile_opcode (tile_opcode),
        .tile_in0    (tile_in0),
        .tile_in1    (tile_in1),
        .tile_out    (tile_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_opcode  (res_opcode),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    // Opcode 3 shows garbage until it has been held for six cycles.
    int mcnt = 0;
    always @(negedge clock) begin
        mcnt     <= (tile_opcode == 4'h3) ? mcnt + 1 : 0;
        tile_out <= (tile_opcode != 4'h3 || mcnt == 5) ? (tile_in0 + tile_in1) : 16'hdead;
    end

    logic [19:0] res_q [$];
    always @(negedge clock) begin
        if (clear_b && res_valid && res_ready) res_q.push_back({res_opcode, res_data});
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [19:0] res_at(input int i);
        if (i < res_q.size()) return res_q[i];
        return 20'hfffff;
    endfunction

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        while (!in_ready && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("push_rdy", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    logic [3:0] bp_ops [6];
    int ptr;

    task automatic bp_step();
        logic rdy;
        logic vld;
        if (ptr < 6) begin
            in_valid  = 1'b1;
            in_opcode = bp_ops[ptr];
            in_a      = 16'h1000 + 16'(ptr);
            in_b      = 16'h0010;
        end else begin
            in_valid = 1'b0;
        end
        rdy = in_ready;
        vld = in_valid;
        @(posedge clock); #1;
        if (vld && rdy) ptr++;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int          first;
        int          nres;
        int          hold;
        logic [15:0] dat;
        logic [3:0]  op;

        vecs[0] = '{4'h1, 16'h8ff8, 16'h8f07, 16'h1eff, 1};
        vecs[1] = '{4'h3, 16'h0001, 16'h0001, 16'h0002, 6};
        vecs[2] = '{4'h2, 16'h0001, 16'hffff, 16'h0000, 1};
        vecs[3] = '{4'h3, 16'h1000, 16'h0234, 16'h1234, 6};
        vecs[4] = '{4'hf, 16'h7fff, 16'h0001, 16'h8000, 1};
        vecs[5] = '{4'h4, 16'h1234, 16'h4321, 16'h5555, 1};
        bp_ops[0] = 4'h1; bp_ops[1] = 4'h2; bp_ops[2] = 4'h4;
        bp_ops[3] = 4'h5; bp_ops[4] = 4'h6; bp_ops[5] = 4'h7;

        clear_b   = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 4'h0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        res_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",    32'(in_ready),    32'd1);
        check("rst_fifo_count",  32'(fifo_count),  32'd0);
        check("rst_res_valid",   32'(res_valid),   32'd0);
        check("rst_tile_opcode", 32'(tile_opcode), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        clear_b = 1'b1;
        @(posedge clock); #1;

        // Single instructions: latency, data, opcode hold window and operand hold.
        for (int i = 0; i < 6; i++) begin
            first = 0; nres = 0; hold = 0; dat = '0; op = '0;
            push(vecs[i].op, vecs[i].a, vecs[i].b);
            for (int k = 1; k <= 12; k++) begin
                @(posedge clock); #1;
                if (tile_opcode == vecs[i].op) hold++;
                if (res_valid) begin
                    nres++;
                    if (first == 0) begin
                        first = k;
                        dat   = res_data;
                        op    = res_opcode;
                    end
                end
            end
            check($sformatf("v%0d_first_edge", i), 32'(first), 32'(vecs[i].lat + 1));
            check($sformatf("v%0d_res_data", i),   32'(dat),   32'(vecs[i].exp));
            check($sformatf("v%0d_res_opcode", i), 32'(op),    32'(vecs[i].op));
            check($sformatf("v%0d_op_hold", i),    32'(hold),  32'(vecs[i].lat));
            check($sformatf("v%0d_res_cycles", i), 32'(nres),  32'd1);
            check($sformatf("v%0d_tile_in0", i),   32'(tile_in0), 32'(vecs[i].a));
            check($sformatf("v%0d_tile_in1", i),   32'(tile_in1), 32'(vecs[i].b));
            check($sformatf("v%0d_busy_end", i),   32'(busy),  32'd0);
        end

        // Backpressure: one in flight plus four buffered, sixth push stalls.
        res_ready = 1'b0;
        res_q.delete();
        ptr = 0;
        for (int c = 0; c < 10; c++) bp_step();
        check("bp_accepted",   32'(ptr),        32'd5);
        check("bp_in_ready",   32'(in_ready),   32'd0);
        check("bp_fifo_count", 32'(fifo_count), 32'd4);
        check("bp_res_valid",  32'(res_valid),  32'd1);
        check("bp_res_opcode", 32'(res_opcode), 32'd1);
        res_ready = 1'b1;
        for (int c = 0; c < 60 && (res_q.size() < 6 || ptr < 6); c++) bp_step();
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("bp_all_accepted", 32'(ptr), 32'd6);
        check("bp_n_results", 32'(res_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_res%0d", i), 32'(res_at(i)), 32'({bp_ops[i], 16'h1010 + 16'(i)}));
        end
        check("bp_busy_end", 32'(busy), 32'd0);

        // NOP skipping.
        res_q.delete();
        push(4'h0, 16'h5555, 16'h5555);
        push(4'h2, 16'h0003, 16'h0004);
        push(4'h0, 16'h5555, 16'h5555);
        push(4'h8, 16'h00f0, 16'h000f);
        repeat (15) @(posedge clock);
        #1;
        check("nop_n_results", 32'(res_q.size()), 32'd2);
        check("nop_res0", 32'(res_at(0)), 32'h2_0007);
        check("nop_res1", 32'(res_at(1)), 32'h8_00ff);
        check("nop_busy_end", 32'(busy), 32'd0);

        // Reset three cycles into a multi-cycle op with two more queued.
        res_q.delete();
        push(4'h3, 16'h0001, 16'h0001);
        push(4'h1, 16'h0002, 16'h0002);
        push(4'h2, 16'h0003, 16'h0003);
        repeat (2) @(posedge clock);
        #1;
        check("mid_tile_opcode", 32'(tile_opcode), 32'd3);
        check("mid_fifo_count",  32'(fifo_count),  32'd2);
        clear_b = 1'b0;
        #1;
        check("flush_tile_opcode", 32'(tile_opcode), 32'd0);
        check("flush_fifo_count",  32'(fifo_count),  32'd0);
        check("flush_res_valid",   32'(res_valid),   32'd0);
        check("flush_in_ready",    32'(in_ready),    32'd1);
        check("flush_busy",        32'(busy),        32'd0);
        check("flush_tile_in0",    32'(tile_in0),    32'd0);
        repeat (3) @(posedge clock);
        #1;
        clear_b = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("flush_no_results", 32'(res_q.size()), 32'd0);
        check("flush_busy_after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
